// File: rtl/fetch_pkg.sv
// Shared types and limits for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state encoding
//   MEM_WAIT_MAX  : largest SRAM wait count the 4-bit wait counter can hold
package fetch_pkg;

  typedef enum logic [2:0] {
    HALTED,
    FETCH_MAR,
    FETCH_RD,
    FETCH_IR,
    PAUSE_WAIT,
    PAUSE_REL
  } fetch_state_t;

  localparam int unsigned MEM_WAIT_MAX = 15;

endpackage

// File: rtl/fetch_sequencer_wait_counter.sv
// wait_counter: 4-bit down-counter with load and zero flag.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears count)
//   load      : load load_val (has priority over dec)
//   dec       : decrement, saturating at zero
//   load_val  : value loaded when load=1
//   zero      : count == 0
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore FSM sequencing the PC/MAR/MDR/IR datapath through
// instruction fetch and driving the synchronous SRAM strobes.
// Parameters: MEM_WAIT (extra SRAM read cycles, 0..15), CNT_W (fetch counter width).
// Ports:
//   Clk, Reset                : clock, synchronous active-high reset
//   Run                       : 1 = fetch continuously, 0 = stop after current fetch
//   Continue                  : releases a single-step pause
//   GATEPC, GATEMDR           : bus / MDR path gates
//   LD_MAR, LD_MDR, LD_IR, LD_PC : register loads
//   MIO_EN, PCMUX_EN          : MDR source select, PC source select
//   Mem_CE_n, Mem_OE_n, Mem_WE_n : SRAM strobes, active low
//   Busy                      : 1 outside HALTED
//   Fetch_Count               : completed IR loads, wrapping
// Build option: define FETCH_STEP_EN to pause after each fetch until Continue
// is pulsed (PAUSE_WAIT / PAUSE_REL states).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Continue,
  output logic             GATEPC,
  output logic             GATEMDR,
  output logic             LD_MAR,
  output logic             LD_MDR,
  output logic             LD_IR,
  output logic             LD_PC,
  output logic             MIO_EN,
  output logic             PCMUX_EN,
  output logic             Mem_CE_n,
  output logic             Mem_OE_n,
  output logic             Mem_WE_n,
  output logic             Busy,
  output logic [CNT_W-1:0] Fetch_Count
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  fetch_state_t state, state_next;
  logic         wait_load, wait_dec, wait_zero, count_inc;

`ifndef FETCH_STEP_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  // The counter is loaded during FETCH_MAR so it already holds MEM_WAIT on
  // the first FETCH_RD cycle; zero then marks the final read cycle.
  wait_counter u_wait (
    .clk      (Clk),
    .rst      (Reset),
    .load     (wait_load),
    .dec      (wait_dec),
    .load_val (WAIT_LOAD),
    .zero     (wait_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= HALTED;
      Fetch_Count <= '0;
    end else begin
      state <= state_next;
      if (count_inc) Fetch_Count <= Fetch_Count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    GATEPC     = 1'b0;
    GATEMDR    = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_PC      = 1'b0;
    MIO_EN     = 1'b0;
    PCMUX_EN   = 1'b0;
    Mem_CE_n   = 1'b1;
    Mem_OE_n   = 1'b1;
    Mem_WE_n   = 1'b1;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    count_inc  = 1'b0;
    unique case (state)
      HALTED: begin
        if (Run) state_next = FETCH_MAR;
      end
      FETCH_MAR: begin
        GATEPC     = 1'b1;
        LD_MAR     = 1'b1;
        LD_PC      = 1'b1;
        PCMUX_EN   = 1'b1;
        wait_load  = 1'b1;
        state_next = FETCH_RD;
      end
      FETCH_RD: begin
        Mem_CE_n = 1'b0;
        Mem_OE_n = 1'b0;
        MIO_EN   = 1'b1;
        wait_dec = 1'b1;
        if (wait_zero) begin
          LD_MDR     = 1'b1;
          state_next = FETCH_IR;
        end
      end
      FETCH_IR: begin
        GATEMDR   = 1'b1;
        LD_IR     = 1'b1;
        count_inc = 1'b1;
`ifdef FETCH_STEP_EN
        state_next = PAUSE_WAIT;
`else
        state_next = Run ? FETCH_MAR : HALTED;
`endif
      end
`ifdef FETCH_STEP_EN
      PAUSE_WAIT: begin
        if (Continue) state_next = PAUSE_REL;
      end
      PAUSE_REL: begin
        if (!Continue) state_next = Run ? FETCH_MAR : HALTED;
      end
`endif
      default: state_next = HALTED;
    endcase
  end

  assign Busy = (state != HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, cont, rst_b, run_b;

  logic gatepc, gatemdr, ld_mar, ld_mdr, ld_ir, ld_pc, mio_en, pcmux_en;
  logic ce_n, oe_n, we_n, busy;
  logic [15:0] cnt;
  logic gatepc_b, gatemdr_b, ld_mar_b, ld_mdr_b, ld_ir_b, ld_pc_b, mio_en_b, pcmux_en_b;
  logic ce_n_b, oe_n_b, we_n_b, busy_b;
  logic [3:0] cnt_b;

  // {GATEPC,GATEMDR,LD_MAR,LD_MDR,LD_IR,LD_PC,MIO_EN,PCMUX_EN,CE_n,OE_n,WE_n,Busy}
  logic [11:0] vec, vec_b;
  assign vec   = {gatepc, gatemdr, ld_mar, ld_mdr, ld_ir, ld_pc, mio_en, pcmux_en,
                  ce_n, oe_n, we_n, busy};
  assign vec_b = {gatepc_b, gatemdr_b, ld_mar_b, ld_mdr_b, ld_ir_b, ld_pc_b, mio_en_b,
                  pcmux_en_b, ce_n_b, oe_n_b, we_n_b, busy_b};

  localparam logic [11:0] V_HALT  = 12'b0000_0000_1110;
  localparam logic [11:0] V_MAR   = 12'b1010_0101_1111;
  localparam logic [11:0] V_RDW   = 12'b0000_0010_0011;
  localparam logic [11:0] V_RDL   = 12'b0001_0010_0011;
  localparam logic [11:0] V_IR    = 12'b0100_1000_1111;
  localparam logic [11:0] V_PAUSE = 12'b0000_0000_1111;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.MEM_WAIT(2), .CNT_W(16)) dut (
    .Clk(clk), .Reset(rst), .Run(run), .Continue(cont),
    .GATEPC(gatepc), .GATEMDR(gatemdr), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .LD_IR(ld_ir), .LD_PC(ld_pc), .MIO_EN(mio_en), .PCMUX_EN(pcmux_en),
    .Mem_CE_n(ce_n), .Mem_OE_n(oe_n), .Mem_WE_n(we_n), .Busy(busy),
    .Fetch_Count(cnt)
  );

  fetch_sequencer #(.MEM_WAIT(0), .CNT_W(4)) dut_b (
    .Clk(clk), .Reset(rst_b), .Run(run_b), .Continue(cont),
    .GATEPC(gatepc_b), .GATEMDR(gatemdr_b), .LD_MAR(ld_mar_b), .LD_MDR(ld_mdr_b),
    .LD_IR(ld_ir_b), .LD_PC(ld_pc_b), .MIO_EN(mio_en_b), .PCMUX_EN(pcmux_en_b),
    .Mem_CE_n(ce_n_b), .Mem_OE_n(oe_n_b), .Mem_WE_n(we_n_b), .Busy(busy_b),
    .Fetch_Count(cnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; cont = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (vec !== V_HALT || cnt !== 16'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: strobes %b cnt %0d, expected %b cnt 0",
                 i, vec, cnt, V_HALT);
      end
    end
  endtask

  // Four back-to-back fetches with MEM_WAIT=2, then a fifth with Run dropped mid-read.
  task automatic test_fetch_wait2();
    logic [11:0] seq [5];
    seq[0] = V_MAR; seq[1] = V_RDW; seq[2] = V_RDW; seq[3] = V_RDL; seq[4] = V_IR;
    run = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 5; k++) begin
        step();
        checks++;
        if (vec !== seq[k]) begin
          errors++;
          $display("FAIL fetch_seq f%0d k%0d: strobes %b, expected %b", f, k, vec, seq[k]);
        end
        if (k == 0) begin
          checks++;
          if (cnt !== 16'(f)) begin
            errors++;
            $display("FAIL fetch_count f%0d: cnt %0d, expected %0d", f, cnt, f);
          end
        end
      end
    end
    step();
    checks++;
    if (vec !== V_MAR || cnt !== 16'd4) begin
      errors++;
      $display("FAIL count_after_20: strobes %b cnt %0d, expected %b cnt 4", vec, cnt, V_MAR);
    end
    step();
    step();
    run = 1'b0;
    checks++;
    if (vec !== V_RDW) begin
      errors++;
      $display("FAIL run_drop_rd2: strobes %b, expected %b", vec, V_RDW);
    end
    step();
    checks++;
    if (vec !== V_RDL) begin
      errors++;
      $display("FAIL run_drop_rd3: strobes %b, expected %b", vec, V_RDL);
    end
    step();
    checks++;
    if (vec !== V_IR) begin
      errors++;
      $display("FAIL run_drop_ir: strobes %b, expected %b", vec, V_IR);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (vec !== V_HALT || cnt !== 16'd5) begin
        errors++;
        $display("FAIL run_drop_halt cyc %0d: strobes %b cnt %0d, expected %b cnt 5",
                 i, vec, cnt, V_HALT);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    run = 1'b1;
    step();
    step();
    checks++;
    if (vec !== V_RDW) begin
      errors++;
      $display("FAIL midrd_setup: strobes %b, expected %b", vec, V_RDW);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; run = 1'b0;
    checks++;
    if (vec !== V_HALT || cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrd_reset: strobes %b cnt %0d, expected %b cnt 0", vec, cnt, V_HALT);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (vec !== V_HALT || cnt !== 16'd0) begin
        errors++;
        $display("FAIL midrd_idle cyc %0d: strobes %b cnt %0d, expected %b cnt 0",
                 i, vec, cnt, V_HALT);
      end
    end
  endtask

  // MEM_WAIT=0, CNT_W=4: 3-cycle period and counter wrap after 16 fetches.
  task automatic test_wait0_wrap();
    logic [11:0] seq [3];
    seq[0] = V_MAR; seq[1] = V_RDL; seq[2] = V_IR;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    checks++;
    if (vec_b !== V_HALT || cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL b_reset: strobes %b cnt %0d, expected %b cnt 0", vec_b, cnt_b, V_HALT);
    end
    run_b = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (vec_b !== seq[k]) begin
          errors++;
          $display("FAIL b_seq f%0d k%0d: strobes %b, expected %b", f, k, vec_b, seq[k]);
        end
        if (k == 0) begin
          checks++;
          if (cnt_b !== 4'(f)) begin
            errors++;
            $display("FAIL b_count f%0d: cnt %0d, expected %0d", f, cnt_b, f);
          end
        end
      end
    end
    step();
    checks++;
    if (vec_b !== V_MAR || cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL b_wrap: strobes %b cnt %0d, expected %b cnt 0", vec_b, cnt_b, V_MAR);
    end
    run_b = 1'b0;
  endtask

  task automatic test_step();
    logic [11:0] seq [5];
    seq[0] = V_MAR; seq[1] = V_RDW; seq[2] = V_RDW; seq[3] = V_RDL; seq[4] = V_IR;
    rst = 1'b1; cont = 1'b0; run = 1'b0;
    step();
    rst = 1'b0; run = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 5; k++) begin
        step();
        checks++;
        if (vec !== seq[k]) begin
          errors++;
          $display("FAIL step_seq f%0d k%0d: strobes %b, expected %b", f, k, vec, seq[k]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        step();
        checks++;
        if (vec !== V_PAUSE || cnt !== 16'(f + 1)) begin
          errors++;
          $display("FAIL step_pause f%0d cyc %0d: strobes %b cnt %0d, expected %b cnt %0d",
                   f, i, vec, cnt, V_PAUSE, f + 1);
        end
      end
      if (f == 0) begin
        cont = 1'b1;
        for (int i = 0; i < 4; i++) begin
          step();
          checks++;
          if (vec !== V_PAUSE) begin
            errors++;
            $display("FAIL step_hold cyc %0d: strobes %b, expected %b", i, vec, V_PAUSE);
          end
        end
        cont = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cont = 1'b0; rst_b = 1'b1; run_b = 1'b0;
    test_reset();
`ifdef FETCH_STEP_EN
    test_step();
`else
    test_fetch_wait2();
    test_reset_mid_read();
    test_wait0_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
